// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: md_op encoding, default latencies
// and the arithmetic helpers used by the E-stage MDU.
package mdu_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // 32x32 -> 64 product; operands are extended to 64 bits first so the
    // low 64 bits of the 64x64 product are the exact result.
    function automatic logic [63:0] mul32(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        is_signed);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = is_signed ? {{32{a[31]}}, a} : {32'd0, a};
        eb = is_signed ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. Signed division goes through
    // magnitudes so truncation is toward zero and the remainder takes the
    // dividend's sign; 0x80000000 / -1 falls out as {0, 0x80000000}.
    function automatic logic [63:0] div32(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        is_signed);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = is_signed & a[31];
        neg_b = is_signed & b[31];
        ma    = neg_a ? (32'd0 - a) : a;
        mb    = neg_b ? (32'd0 - b) : b;
        q     = (mb == 32'd0) ? 32'd0 : (ma / mb);
        r     = (mb == 32'd0) ? 32'd0 : (ma % mb);
        if (neg_a ^ neg_b) q = 32'd0 - q;
        if (neg_a) r = 32'd0 - r;
        return {r, q};
    endfunction

endpackage

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit owning HI/LO with fixed MULT/DIV latency.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by MDU_MADD_EN.
module mdu_e
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  md_op_e      md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        cancel,
    output logic        busy,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out,
    output logic [31:0] md_out
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MUL_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    mdu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d;
    logic [31:0]   pend_lo_q, pend_lo_d;
    logic          pend_we_q, pend_we_d;
    logic          accept;

    assign accept = start & ~cancel & (state_q == ST_IDLE);

    // Next-state: launch ops from IDLE, count down and retire in RUN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        if (state_q == ST_RUN) begin
            cnt_d = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
                state_d = ST_IDLE;
                if (pend_we_q) begin
                    hi_d = pend_hi_q;
                    lo_d = pend_lo_q;
                end
            end
        end else if (accept) begin
            case (md_op)
                MD_MULT, MD_MULTU: begin
                    {pend_hi_d, pend_lo_d} = mul32(A, B, md_op == MD_MULT);
                    pend_we_d = 1'b1;
                    cnt_d     = MUL_LOAD;
                    state_d   = ST_RUN;
                end
                MD_DIV, MD_DIVU: begin
                    {pend_hi_d, pend_lo_d} = div32(A, B, md_op == MD_DIV);
                    pend_we_d = (B != 32'd0);
                    cnt_d     = DIV_LOAD;
                    state_d   = ST_RUN;
                end
`ifdef MDU_MADD_EN
                MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
                    if ((md_op == MD_MSUB) || (md_op == MD_MSUBU))
                        {pend_hi_d, pend_lo_d} = {hi_q, lo_q} -
                            mul32(A, B, md_op == MD_MSUB);
                    else
                        {pend_hi_d, pend_lo_d} = {hi_q, lo_q} +
                            mul32(A, B, md_op == MD_MADD);
                    pend_we_d = 1'b1;
                    cnt_d     = MUL_LOAD;
                    state_d   = ST_RUN;
                end
`endif
                MD_MTHI: hi_d = A;
                MD_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    // State, counter, HI/LO and pending-result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

    // Read side: busy is the registered state, MFHI/MFLO mux is live.
    always_comb begin
        busy   = (state_q == ST_RUN);
        HI_out = hi_q;
        LO_out = lo_q;
        case (md_op)
            MD_MFHI: md_out = hi_q;
            MD_MFLO: md_out = lo_q;
            default: md_out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mdu_e.sv
// Directed self-checking bench for the E-stage multiply/divide unit.
// Build with +define+MDU_MADD_EN to cover the accumulate ops.
`timescale 1ns/1ps
module tb_mdu_e;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    md_op_e      md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        cancel;
    logic        busy;
    logic [31:0] HI_out;
    logic [31:0] LO_out;
    logic [31:0] md_out;

    int total;
    int fails;

    mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .A      (A),
        .B      (B),
        .cancel (cancel),
        .busy   (busy),
        .HI_out (HI_out),
        .LO_out (LO_out),
        .md_out (md_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The hazard unit never issues while busy; flag it if the bench does.
    always @(posedge clk) begin
        if (start && busy && !reset) begin
            total++;
            fails++;
            $display("FAIL start_while_busy: start=1 busy=1 required busy=0");
        end
    end

    // Drive one op for one cycle; returns at the negedge after its edge.
    task automatic issue(input md_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic c);
        @(negedge clk);
        start  = 1'b1;
        md_op  = op;
        A      = a;
        B      = b;
        cancel = c;
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        md_op  = MD_NONE;
    endtask

    // Count busy cycles starting at the current negedge, bounded.
    task automatic count_busy(output int n, output logic hl_moved);
        logic [31:0] h0;
        logic [31:0] l0;
        h0 = HI_out;
        l0 = LO_out;
        hl_moved = 1'b0;
        n = 0;
        while (busy && n < 50) begin
            n++;
            if (HI_out !== h0 || LO_out !== l0) hl_moved = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        cancel = 1'b0;
        md_op  = MD_NONE;
        A      = 32'd0;
        B      = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, HI_out, LO_out, md_out} !== 97'd0) begin
            fails++;
            $display("FAIL reset_state: busy=%0b hi=%h lo=%h md=%h required all 0",
                     busy, HI_out, LO_out, md_out);
        end
    endtask

    task automatic test_mult();
        int n;
        logic mv;
        issue(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
        count_busy(n, mv);
        total++;
        if (n !== 5) begin
            fails++;
            $display("FAIL mult_busy_len: got %0d required 5", n);
        end
        total++;
        if (HI_out !== 32'hFFFFFFFF || LO_out !== 32'hFFFFFFFA) begin
            fails++;
            $display("FAIL mult_result: hi=%h lo=%h required ffffffff fffffffa",
                     HI_out, LO_out);
        end
        md_op = MD_MFLO;
        #1;
        total++;
        if (md_out !== 32'hFFFFFFFA) begin
            fails++;
            $display("FAIL mflo: got %h required fffffffa", md_out);
        end
        md_op = MD_MFHI;
        #1;
        total++;
        if (md_out !== 32'hFFFFFFFF) begin
            fails++;
            $display("FAIL mfhi: got %h required ffffffff", md_out);
        end
        md_op = MD_NONE;
        #1;
        total++;
        if (md_out !== 32'd0) begin
            fails++;
            $display("FAIL md_out_none: got %h required 0", md_out);
        end
    endtask

    task automatic test_multu();
        int n;
        logic mv;
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        count_busy(n, mv);
        total++;
        if (HI_out !== 32'hFFFFFFFE || LO_out !== 32'h00000001) begin
            fails++;
            $display("FAIL multu_result: hi=%h lo=%h required fffffffe 00000001",
                     HI_out, LO_out);
        end
    endtask

    task automatic test_divu();
        int n;
        logic mv;
        issue(MD_MULT, 32'hFFFFFFFE, 32'd3, 1'b0);
        count_busy(n, mv);
        issue(MD_DIVU, 32'd100, 32'd7, 1'b0);
        cancel = 1'b1;
        count_busy(n, mv);
        cancel = 1'b0;
        total++;
        if (n !== 10) begin
            fails++;
            $display("FAIL divu_busy_len: got %0d required 10", n);
        end
        total++;
        if (mv !== 1'b0) begin
            fails++;
            $display("FAIL divu_hilo_hold: moved=%0b required 0", mv);
        end
        total++;
        if (HI_out !== 32'd2 || LO_out !== 32'd14) begin
            fails++;
            $display("FAIL divu_result: hi=%h lo=%h required 2 e", HI_out, LO_out);
        end
    endtask

    task automatic test_div_signed();
        int n;
        logic mv;
        issue(MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        count_busy(n, mv);
        total++;
        if (HI_out !== 32'hFFFFFFFF || LO_out !== 32'hFFFFFFFD) begin
            fails++;
            $display("FAIL div_signed: hi=%h lo=%h required ffffffff fffffffd",
                     HI_out, LO_out);
        end
        issue(MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        count_busy(n, mv);
        total++;
        if (HI_out !== 32'd0 || LO_out !== 32'h80000000) begin
            fails++;
            $display("FAIL div_overflow: hi=%h lo=%h required 0 80000000",
                     HI_out, LO_out);
        end
    endtask

    task automatic test_mt_cancel();
        issue(MD_MTHI, 32'hAAAA5555, 32'd0, 1'b0);
        issue(MD_MTHI, 32'h12345678, 32'd0, 1'b1);
        total++;
        if (HI_out !== 32'hAAAA5555 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mthi_cancel: hi=%h busy=%0b required aaaa5555 0",
                     HI_out, busy);
        end
        issue(MD_MTHI, 32'h12345678, 32'd0, 1'b0);
        total++;
        if (HI_out !== 32'h12345678 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mthi: hi=%h busy=%0b required 12345678 0", HI_out, busy);
        end
        issue(MD_MTLO, 32'h0BADF00D, 32'd0, 1'b0);
        total++;
        if (LO_out !== 32'h0BADF00D || HI_out !== 32'h12345678) begin
            fails++;
            $display("FAIL mtlo: hi=%h lo=%h required 12345678 0badf00d",
                     HI_out, LO_out);
        end
        issue(MD_MULT, 32'd9, 32'd9, 1'b1);
        total++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL mult_cancel: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_div_zero();
        int n;
        logic mv;
        issue(MD_MTHI, 32'd5, 32'd0, 1'b0);
        issue(MD_MTLO, 32'd9, 32'd0, 1'b0);
        issue(MD_DIV, 32'd77, 32'd0, 1'b0);
        count_busy(n, mv);
        total++;
        if (n !== 10) begin
            fails++;
            $display("FAIL divzero_busy_len: got %0d required 10", n);
        end
        total++;
        if (HI_out !== 32'd5 || LO_out !== 32'd9) begin
            fails++;
            $display("FAIL divzero_hold: hi=%h lo=%h required 5 9", HI_out, LO_out);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        issue(MD_MULT, 32'd7, 32'd7, 1'b0);
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || HI_out !== 32'd0 || LO_out !== 32'd0) begin
            fails++;
            $display("FAIL reset_mid: busy=%0b hi=%h lo=%h required 0 0 0",
                     busy, HI_out, LO_out);
        end
        @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || HI_out !== 32'd0 || LO_out !== 32'd0) n++;
        end
        total++;
        if (n !== 0) begin
            fails++;
            $display("FAIL reset_no_late_write: bad cycles=%0d required 0", n);
        end
    endtask

`ifdef MDU_MADD_EN
    task automatic test_madd();
        int n;
        logic mv;
        issue(MD_MTHI, 32'd0, 32'd0, 1'b0);
        issue(MD_MTLO, 32'hFFFFFFFF, 32'd0, 1'b0);
        issue(MD_MADDU, 32'd1, 32'd1, 1'b0);
        count_busy(n, mv);
        total++;
        if (n !== 5 || HI_out !== 32'd1 || LO_out !== 32'd0) begin
            fails++;
            $display("FAIL maddu: n=%0d hi=%h lo=%h required 5 1 0",
                     n, HI_out, LO_out);
        end
        issue(MD_MSUB, 32'd2, 32'd3, 1'b0);
        count_busy(n, mv);
        total++;
        if (HI_out !== 32'd0 || LO_out !== 32'hFFFFFFFA) begin
            fails++;
            $display("FAIL msub: hi=%h lo=%h required 0 fffffffa", HI_out, LO_out);
        end
    endtask
`else
    task automatic test_madd();
        int n;
        logic mv;
        issue(MD_MTHI, 32'd3, 32'd0, 1'b0);
        issue(MD_MTLO, 32'd4, 32'd0, 1'b0);
        issue(MD_MADDU, 32'd1, 32'd1, 1'b0);
        count_busy(n, mv);
        total++;
        if (n !== 0 || HI_out !== 32'd3 || LO_out !== 32'd4) begin
            fails++;
            $display("FAIL madd_disabled: n=%0d hi=%h lo=%h required 0 3 4",
                     n, HI_out, LO_out);
        end
    endtask
`endif

    initial begin
        total = 0;
        fails = 0;
        test_reset();
        test_mult();
        test_multu();
        test_divu();
        test_div_signed();
        test_mt_cancel();
        test_div_zero();
        test_madd();
        test_reset_mid();
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
